write_buffer_responder: RTL and testbench
=========================================

# write_buffer_responder

Receiving end of the write-request handshake used by the output-buffer writer. It grants requests by raising `ready` and captures the word presented with `write_in_buffer` into a small circular buffer. A downstream consumer drains that buffer through a one-word-per-request read port. The block sits between the producer's write controller and the memory/output stage.

## Interface
- `DATA_WIDTH`, 16, width of stored words
- `DEPTH`, 4, buffer entries; power of two, ≥ 2
- `CNT_W`, clog2(DEPTH)+1, width of the occupancy count
- `clk`  input  1  system clock, rising edge
- `rst`  input  1  one clock; reset is synchronous and active-low (`rst`=0 at a rising edge resets the block)
- `write_req`  input  1  producer requests a write slot; level, held until served or withdrawn
- `write_in_buffer`  input  1  one-cycle strobe; `din` valid, capture now
- `din`  input  DATA_WIDTH  write data
- `ready`  output  1  slot granted; producer may strobe `write_in_buffer`
- `read_req`  input  1  consumer requests one word
- `dout`  output  DATA_WIDTH  read data, registered
- `dout_valid`  output  1  one-cycle pulse, `dout` valid
- `count`  output  CNT_W  current occupancy
- `full`  output  1  `count == DEPTH`
- `empty`  output  1  `count == 0`
- `proto_err`  output  1  sticky; `write_in_buffer` seen while `ready`=0

## Operation
- Storage: DEPTH×DATA_WIDTH array; `wr_ptr` and `rd_ptr` each log2(DEPTH) bits, wrap modulo DEPTH; `count` tracked separately and is 0..DEPTH.
- Write FSM, 2 states, registered:
  - IDLE: `ready`=0. If `write_req`=1 and `count` < DEPTH, go to GRANT. Otherwise stay in IDLE.
  - GRANT: `ready`=1.
    - If `write_in_buffer`=1: mem[`wr_ptr`] ← `din`, `wr_ptr`++, go to IDLE.
    - Else if `write_req`=0 (request withdrawn): go to IDLE, no write.
    - Else stay in GRANT, indefinitely.
- A grant is never issued while `full`. Only one grant is outstanding at a time, so a granted write cannot overflow.
- `write_in_buffer`=1 outside GRANT: no write, pointers unchanged, `proto_err` ← 1. Only reset clears `proto_err`.
- Read: if `read_req`=1 and `count` > 0 at an edge: `dout` ← mem[`rd_ptr`], `rd_ptr`++, `dout_valid`=1 for the next cycle. Otherwise `dout_valid`=0 and `dout` holds its value.
- `read_req` while empty: ignored, no error.
- Simultaneous accepted write and accepted read in one cycle: both occur and `count` is unchanged.
  - Read on empty with a simultaneous write: the read is ignored (no bypass); the word becomes readable next cycle.
- `count`: +1 on write only, −1 on read only. `full` and `empty` are derived combinationally from the registered `count`.

## Timing
- Reset values: `ready`=0, `dout`=0, `dout_valid`=0, `count`=0, `full`=0, `empty`=1, `proto_err`=0. Reset also sets state to IDLE and both pointers to 0.
- Reset mid-operation, including during GRANT: everything returns to reset values at that edge. Buffered data is discarded.
- Grant latency: `write_req` sampled high in IDLE at edge N → `ready`=1 during cycle N+1.
- Capture: `write_in_buffer` high during a GRANT cycle → written at the closing edge. `ready`=0 and `count` updated in the following cycle.
- Write throughput: at most one word per 2 cycles, because IDLE is always re-entered.
- Read latency: `read_req` sampled at edge M → `dout`/`dout_valid` valid in cycle M+1. Sustained reads give 1 word per cycle while non-empty.
- Ordering is strict FIFO, including across pointer wrap.

## Test plan
- Reset then single write:
  - Stimulus: `rst`=0 for 2 cycles; `write_req`=1 → `ready`=1 on the next cycle.
  - Strobe `write_in_buffer` with `din`=0x00A5 → `count`=1, `empty`=0, `ready`=0.
  - Read → `dout`=0x00A5 with a 1-cycle `dout_valid`.
- Fill and stall:
  - Stimulus: write 4 words 0x1,0x2,0x3,0x4 → `full`=1.
  - Fifth `write_req` held 10 cycles → `ready` stays 0.
  - One read → `ready`=1 within 2 cycles; 0x1 is returned first.
- Wrap-around: 6 writes interleaved with reads of values 0x10–0x15 → reads return 0x10..0x15 in order and `count` never exceeds 4.
- Simultaneous: `count`=2; `write_in_buffer` during GRANT and `read_req` in the same cycle → `count` stays 2 and the oldest word is output.
- Withdrawal and protocol error:
  - Drop `write_req` while in GRANT → `ready`=0 next cycle and `count` unchanged.
  - Strobe `write_in_buffer` while `ready`=0 → `proto_err`=1 and it stays set until `rst`=0.
- Reset mid-transfer: `rst`=0 during GRANT with `count`=3 → `ready`=0, `count`=0, `empty`=1 next cycle.

Source files
------------

// File: rtl/write_buffer_responder.sv
// write_buffer_responder: grants producer write slots one at a time and
// queues the captured words in a small circular buffer drained by a
// one-word-per-request read port.
module write_buffer_responder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_req,
  input  logic                  write_in_buffer,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  ready,
  input  logic                  read_req,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  proto_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  proto_err_q, proto_err_d;
  logic                  wr_en_c, rd_en_c, err_set_c;

  // Write FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Write FSM next state: grant only with room, always return to IDLE after a grant
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (write_req && (count_q < CNT_W'(DEPTH))) state_d = S_GRANT;
      end
      S_GRANT: begin
        if (write_in_buffer)  state_d = S_IDLE;
        else if (!write_req)  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write FSM outputs: accepted write and protocol-error detection
  always_comb begin
    wr_en_c   = 1'b0;
    err_set_c = 1'b0;
    if (state_q == S_GRANT) wr_en_c   = write_in_buffer;
    else                    err_set_c = write_in_buffer;
  end

  // Datapath next state: pointers, occupancy, read register, sticky error
  always_comb begin
    rd_en_c      = read_req && (count_q != '0);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = rd_en_c;
    proto_err_d  = proto_err_q | err_set_c;
    if (wr_en_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      dout_d   = mem_q[rd_ptr_q];
    end
    case ({wr_en_c, rd_en_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Datapath registers; buffered data is discarded on reset via the pointers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Storage array, written only on an accepted write
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= din;
  end

  assign ready      = (state_q == S_GRANT);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign count      = count_q;
  assign proto_err  = proto_err_q;
  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);

endmodule

// File: tb/tb_write_buffer_responder.sv
// Randomized + directed bench for write_buffer_responder with a queue-based
// reference model and a scoreboard of expected read words.
module tb_write_buffer_responder;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          write_req, write_in_buffer, read_req;
  logic [DW-1:0] din;
  logic          ready, dout_valid, full, empty, proto_err;
  logic [DW-1:0] dout;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  write_buffer_responder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .write_req(write_req), .write_in_buffer(write_in_buffer), .din(din),
    .ready(ready), .read_req(read_req), .dout(dout), .dout_valid(dout_valid),
    .count(count), .full(full), .empty(empty), .proto_err(proto_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: buffer contents as a queue, plus grant/error flags
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  bit            m_grant, m_perr, m_dv, chk_en;
  int            m_sz;
  bit            m_wr, m_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Model update at each rising edge using the inputs held stable since negedge
  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      exp_q.delete();
      m_grant = 1'b0;
      m_perr  = 1'b0;
      m_dv    = 1'b0;
    end else begin
      m_sz = mq.size();
      m_wr = m_grant && write_in_buffer;
      m_rd = read_req && (m_sz > 0);
      m_dv = m_rd;
      if (m_rd) exp_q.push_back(mq.pop_front());
      if (m_wr) mq.push_back(din);
      if (write_in_buffer && !m_grant) m_perr = 1'b1;
      if (m_grant) m_grant = write_req && !write_in_buffer;
      else         m_grant = write_req && (m_sz < DEPTH);
    end
  end

  // Monitor: compare status every cycle, pop scoreboard on each dout_valid
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 32'(ready), 32'(m_grant));
      check("count", 32'(count), 32'(mq.size()));
      check("full", 32'(full), 32'(mq.size() == DEPTH));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("proto_err", 32'(proto_err), 32'(m_perr));
      check("dout_valid", 32'(dout_valid), 32'(m_dv));
      if (dout_valid) begin
        if (exp_q.size() == 0) fail_now("dout_unexpected");
        else check("dout", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !ready; i++) @(negedge clk);
    if (!ready) fail_now("ready_timeout");
  endtask

  task automatic do_write(input logic [DW-1:0] data);
    write_req = 1'b1;
    @(negedge clk);
    wait_ready();
    if (ready) begin
      write_in_buffer = 1'b1;
      din = data;
      @(negedge clk);
      write_in_buffer = 1'b0;
    end
    write_req = 1'b0;
  endtask

  task automatic do_read();
    read_req = 1'b1;
    @(negedge clk);
    read_req = 1'b0;
  endtask

  task automatic drain();
    read_req = 1'b1;
    cyc(DEPTH + 2);
    read_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b0; write_req = 1'b0; write_in_buffer = 1'b0; read_req = 1'b0; din = '0;
    chk_en = 1'b0;
    cyc(2);
    chk_en = 1'b1;
    check("reset_dout", 32'(dout), 32'h0);
    rst = 1'b1;

    // Single write then read
    do_write(16'h00A5);
    @(negedge clk);
    do_read();
    @(negedge clk);

    // Fill, stall a fifth request, then free a slot
    for (int i = 1; i <= 4; i++) do_write(DW'(i));
    check("full_after_fill", 32'(full), 32'h1);
    write_req = 1'b1;
    cyc(10);
    check("stall_ready", 32'(ready), 32'h0);
    read_req = 1'b1;
    @(negedge clk);
    read_req = 1'b0;
    n = 1;
    while (!ready && n < 10) begin @(negedge clk); n++; end
    check("grant_after_read_cycles", 32'(n <= 2), 32'h1);
    write_in_buffer = 1'b1; din = 16'h0005;
    @(negedge clk);
    write_in_buffer = 1'b0; write_req = 1'b0;
    drain();

    // Wrap-around with interleaved reads
    for (int i = 0; i < 6; i++) begin
      do_write(DW'(16'h10 + i));
      do_read();
    end
    drain();

    // Simultaneous write and read at count 2
    do_write(16'h0021);
    do_write(16'h0022);
    write_req = 1'b1;
    @(negedge clk);
    wait_ready();
    write_in_buffer = 1'b1; din = 16'h0023; read_req = 1'b1;
    @(negedge clk);
    write_in_buffer = 1'b0; read_req = 1'b0; write_req = 1'b0;
    check("simul_count", 32'(count), 32'h2);
    drain();

    // Withdrawal, then a stray strobe raises the sticky error
    write_req = 1'b1;
    @(negedge clk);
    wait_ready();
    write_req = 1'b0;
    cyc(2);
    write_in_buffer = 1'b1; din = 16'hDEAD;
    @(negedge clk);
    write_in_buffer = 1'b0;
    cyc(5);
    check("proto_err_sticky", 32'(proto_err), 32'h1);

    // Reset during GRANT with three words buffered
    for (int i = 0; i < 3; i++) do_write(DW'(16'h30 + i));
    write_req = 1'b1;
    @(negedge clk);
    wait_ready();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; write_req = 1'b0;
    check("midreset_count", 32'(count), 32'h0);
    check("midreset_empty", 32'(empty), 32'h1);
    check("midreset_ready", 32'(ready), 32'h0);
    @(negedge clk);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      write_req       = ($urandom_range(0, 3) != 0);
      read_req        = ($urandom_range(0, 2) == 0);
      din             = DW'($urandom);
      write_in_buffer = ready ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 60) == 0);
      rst             = ($urandom_range(0, 200) != 0);
      @(negedge clk);
      check("count_bound", 32'(count <= CW'(DEPTH)), 32'h1);
    end
    rst = 1'b1; write_req = 1'b0; write_in_buffer = 1'b0; read_req = 1'b0;
    @(negedge clk);
    drain();
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
